// File: rtl/score_recorder.sv
// Records note keys into the MusicScore RAM as {key code, duration} entries,
// closing every recording with a {0,0} end-of-score marker.
module score_recorder #(
  parameter int AddressBits  = 5,
  parameter int DataLength   = 4,
  parameter int StartAddress = 0,
  parameter int TickCycles   = 12500000
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   Record,
  input  logic [2:0]             Keys,
  output logic                   ReadOrWrite,
  output logic [AddressBits-1:0] Address,
  output logic [DataLength-1:0]  KeyData,
  output logic [DataLength-1:0]  TimeData,
  output logic                   Recording,
  output logic                   Full,
  output logic [2:0]             dbg_state
);

  localparam int TW = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam logic [TW-1:0]          TickLast  = TW'(TickCycles - 1);
  localparam logic [TW-1:0]          TickOne   = (TickCycles > 1) ? TW'(1) : '0;
  localparam logic [DataLength-1:0]  UnitsOne  = (TickCycles > 1) ? '0 : DataLength'(1);
  localparam logic [DataLength-1:0]  UnitsMax  = '1;
  localparam logic [AddressBits-1:0] AddrFirst = AddressBits'(StartAddress);
  localparam logic [AddressBits-1:0] AddrLast  = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_KEY = 3'd1,
    MEASURE  = 3'd2,
    WRITE    = 3'd3,
    END      = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [DataLength-1:0]  key_code_q, key_code_d;
  logic [DataLength-1:0]  cur_key_q, cur_key_d;
  logic [DataLength-1:0]  next_key_q, next_key_d;
  logic [DataLength-1:0]  units_q, units_d;
  logic [DataLength-1:0]  wr_units_q, wr_units_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [AddressBits-1:0] addr_q, addr_d;
  logic                   stop_q, stop_d;
  logic                   full_q, full_d;
  logic                   rw_q, rw_d;
  logic [AddressBits-1:0] addr_out_q, addr_out_d;
  logic [DataLength-1:0]  key_out_q, key_out_d;
  logic [DataLength-1:0]  time_out_q, time_out_d;

  logic                   wrap;
  logic [TW-1:0]          tick_cnt;
  logic [DataLength-1:0]  units_cnt;
  logic [AddressBits-1:0] addr_inc;

  // Counters always track the segment whose code is currently registered, so
  // the cycle in which a new code appears already belongs to the new segment.
  always_comb begin
    wrap      = (tick_q == TickLast);
    tick_cnt  = wrap ? '0 : tick_q + TW'(1);
    units_cnt = (wrap && units_q != UnitsMax) ? units_q + DataLength'(1) : units_q;
    addr_inc  = addr_q + AddressBits'(1);

    state_d    = state_q;
    cur_key_d  = cur_key_q;
    next_key_d = next_key_q;
    units_d    = units_q;
    wr_units_d = wr_units_q;
    tick_d     = tick_q;
    addr_d     = addr_q;
    stop_d     = stop_q;
    full_d     = full_q;
    rw_d       = 1'b1;
    addr_out_d = addr_q;
    key_out_d  = key_out_q;
    time_out_d = time_out_q;

    if (Keys[0])      key_code_d = DataLength'(1);
    else if (Keys[1]) key_code_d = DataLength'(2);
    else if (Keys[2]) key_code_d = DataLength'(3);
    else              key_code_d = '0;

    case (state_q)
      IDLE: begin
        if (Record) begin
          state_d = WAIT_KEY;
          addr_d  = AddrFirst;
          full_d  = 1'b0;
        end
      end
      WAIT_KEY: begin
        if (Record) begin
          state_d = END;
        end else if (key_code_q != '0) begin
          state_d   = MEASURE;
          cur_key_d = key_code_q;
          tick_d    = TickOne;
          units_d   = UnitsOne;
        end
      end
      MEASURE: begin
        if (Record) begin
          state_d    = WRITE;
          wr_units_d = units_q;
          stop_d     = 1'b1;
          next_key_d = cur_key_q;
        end else if (key_code_q != cur_key_q) begin
          state_d    = WRITE;
          wr_units_d = units_q;
          stop_d     = 1'b0;
          next_key_d = key_code_q;
          tick_d     = TickOne;
          units_d    = UnitsOne;
        end else if (wrap && units_cnt == UnitsMax) begin
          state_d    = WRITE;
          wr_units_d = UnitsMax;
          stop_d     = 1'b0;
          next_key_d = cur_key_q;
          tick_d     = '0;
          units_d    = '0;
        end else begin
          tick_d  = tick_cnt;
          units_d = units_cnt;
        end
      end
      WRITE: begin
        tick_d    = tick_cnt;
        units_d   = units_cnt;
        cur_key_d = next_key_q;
        state_d   = stop_q ? END : MEASURE;
        if (wr_units_q != '0) begin
          rw_d       = 1'b0;
          key_out_d  = cur_key_q;
          time_out_d = wr_units_q;
          addr_d     = addr_inc;
          if (addr_inc == AddrLast) begin
            state_d = END;
            full_d  = 1'b1;
          end
        end
      end
      END: begin
        rw_d       = 1'b0;
        key_out_d  = '0;
        time_out_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The RAM port is driven from registers so the strobe and its address/data
  // change together on a clock edge and stay stable for the whole cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      key_code_q <= '0;
      cur_key_q  <= '0;
      next_key_q <= '0;
      units_q    <= '0;
      wr_units_q <= '0;
      tick_q     <= '0;
      addr_q     <= AddrFirst;
      stop_q     <= 1'b0;
      full_q     <= 1'b0;
      rw_q       <= 1'b1;
      addr_out_q <= AddrFirst;
      key_out_q  <= '0;
      time_out_q <= '0;
    end else begin
      state_q    <= state_d;
      key_code_q <= key_code_d;
      cur_key_q  <= cur_key_d;
      next_key_q <= next_key_d;
      units_q    <= units_d;
      wr_units_q <= wr_units_d;
      tick_q     <= tick_d;
      addr_q     <= addr_d;
      stop_q     <= stop_d;
      full_q     <= full_d;
      rw_q       <= rw_d;
      addr_out_q <= addr_out_d;
      key_out_q  <= key_out_d;
      time_out_q <= time_out_d;
    end
  end

  assign ReadOrWrite = rw_q;
  assign Address     = addr_out_q;
  assign KeyData     = key_out_q;
  assign TimeData    = time_out_q;
  assign Recording   = (state_q != IDLE);
  assign Full        = full_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_score_recorder.sv
// Directed bench for score_recorder: captures every RAM write strobe and
// compares the recorded {address, key, time} entries with hand-computed lists.
module tb_score_recorder;

  logic       CLK;
  logic       RESET;
  logic       Record;
  logic [2:0] Keys;
  logic       ReadOrWrite;
  logic [4:0] Address;
  logic [3:0] KeyData;
  logic [3:0] TimeData;
  logic       Recording;
  logic       Full;
  logic [2:0] dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  logic [12:0] obs_q[$];
  logic [12:0] exp_q[$];

  localparam logic [2:0] K_NONE = 3'b000;
  localparam logic [2:0] K_C    = 3'b001;
  localparam logic [2:0] K_D    = 3'b010;
  localparam logic [2:0] K_E    = 3'b100;

  score_recorder #(
    .AddressBits(5),
    .DataLength(4),
    .StartAddress(0),
    .TickCycles(4)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .Record(Record),
    .Keys(Keys),
    .ReadOrWrite(ReadOrWrite),
    .Address(Address),
    .KeyData(KeyData),
    .TimeData(TimeData),
    .Recording(Recording),
    .Full(Full),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // write-port monitor: one entry per strobe cycle
  always @(negedge CLK) begin
    if (RESET && !ReadOrWrite) obs_q.push_back({Address, KeyData, TimeData});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [2:0] k, input logic r, input int n);
    repeat (n) begin
      @(negedge CLK);
      Keys   = k;
      Record = r;
    end
  endtask

  task automatic rec_start();
    drive(K_NONE, 1'b1, 1);
    drive(K_NONE, 1'b0, 1);
  endtask

  // release the keys, then pulse Record in the cycle the released code is seen
  task automatic rec_stop();
    drive(K_NONE, 1'b0, 1);
    drive(K_NONE, 1'b1, 1);
    drive(K_NONE, 1'b0, 6);
  endtask

  task automatic expect_entry(input int a, input int k, input int t);
    exp_q.push_back({5'(a), 4'(k), 4'(t)});
  endtask

  // scoreboard: compare captured writes with the expected list, then clear both
  task automatic score(input string name);
    int n;
    check({name, ".count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.entry%0d", name, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int cnt;
    int seen;
    RESET  = 1'b0;
    Record = 1'b0;
    Keys   = K_NONE;
    repeat (3) @(negedge CLK);
    check("rst.rw",   ReadOrWrite, 1);
    check("rst.addr", Address, 0);
    check("rst.key",  KeyData, 0);
    check("rst.time", TimeData, 0);
    check("rst.rec",  Recording, 0);
    check("rst.full", Full, 0);
    RESET = 1'b1;
    drive(K_NONE, 1'b0, 2);

    // basic: C 12 cycles -> 3 units, D 8 cycles -> 2 units
    rec_start();
    check("basic.recording", Recording, 1);
    drive(K_C, 1'b0, 12);
    drive(K_D, 1'b0, 8);
    rec_stop();
    expect_entry(0, 1, 3);
    expect_entry(1, 2, 2);
    expect_entry(2, 0, 0);
    score("basic");
    check("basic.rec_low", Recording, 0);
    check("basic.full", Full, 0);

    // saturation: E 70 cycles -> {3,15} then remainder 10 cycles -> {3,2}
    rec_start();
    drive(K_E, 1'b0, 70);
    rec_stop();
    expect_entry(0, 3, 15);
    expect_entry(1, 3, 2);
    expect_entry(2, 0, 0);
    score("sat");

    // leading silence and a sub-unit glitch produce no entries
    rec_start();
    drive(K_NONE, 1'b0, 20);
    drive(K_D, 1'b0, 2);
    drive(K_C, 1'b0, 8);
    rec_stop();
    expect_entry(0, 1, 2);
    expect_entry(1, 0, 0);
    score("glitch");

    // full: 4-cycle alternating notes fill addresses 0..30, marker at 31
    rec_start();
    for (int i = 0; i < 40; i++) drive((i % 2) ? K_D : K_C, 1'b0, 4);
    drive(K_NONE, 1'b0, 8);
    for (int i = 0; i < 31; i++) expect_entry(i, (i % 2) ? 2 : 1, 1);
    expect_entry(31, 0, 0);
    score("full");
    check("full.flag", Full, 1);
    check("full.rec_low", Recording, 0);
    check("full.idle", dbg_state, 0);

    // collision: Record in the cycle the code changes C->E
    rec_start();
    check("coll.full_cleared", Full, 0);
    drive(K_C, 1'b0, 12);
    drive(K_E, 1'b0, 1);
    drive(K_E, 1'b1, 1);
    drive(K_NONE, 1'b0, 8);
    expect_entry(0, 1, 3);
    expect_entry(1, 0, 0);
    score("coll");

    // reset during MEASURE
    rec_start();
    drive(K_C, 1'b0, 6);
    check("rstm.state", dbg_state, 2);
    #1 RESET = 1'b0;
    #1;
    check("rstm.rw",   ReadOrWrite, 1);
    check("rstm.addr", Address, 0);
    check("rstm.key",  KeyData, 0);
    check("rstm.time", TimeData, 0);
    check("rstm.rec",  Recording, 0);
    drive(K_NONE, 1'b0, 1);
    RESET = 1'b1;
    drive(K_NONE, 1'b0, 2);

    // reset during a WRITE cycle: the pending strobe must never appear
    rec_start();
    drive(K_C, 1'b0, 8);
    Keys = K_D;
    cnt  = 0;
    seen = 0;
    while (cnt < 10 && !seen) begin
      @(negedge CLK);
      if (dbg_state == 3'd3) seen = 1;
      cnt++;
    end
    check("rstw.reached_write", seen, 1);
    #1 RESET = 1'b0;
    #1;
    check("rstw.rw",  ReadOrWrite, 1);
    check("rstw.rec", Recording, 0);
    drive(K_NONE, 1'b0, 3);
    RESET = 1'b1;
    drive(K_NONE, 1'b0, 3);
    score("rstw");

    // restart after reset begins at StartAddress
    rec_start();
    drive(K_C, 1'b0, 8);
    rec_stop();
    expect_entry(0, 1, 2);
    expect_entry(1, 0, 0);
    score("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/score_recorder.md
Name: score_recorder

Overview:
- Write-side counterpart of the score player. Samples the three debounced note keys, measures how long each key (or rest) is held, and writes {key code, duration} entries into the MusicScore RAM through its write port.
- An end-of-score marker terminates each recording, so the player reads the recording back unchanged.
- Sits between the key debouncers / ClockedOneShot and the MusicScore write port.

Parameters:
- AddressBits, 5, RAM address width.
- DataLength, 4, width of the key and time fields.
- StartAddress, 0, first RAM address written.
- TickCycles, 12500000, CLK cycles per duration unit (1/8 s at 100 MHz). Set to 4 in simulation.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- Record  input  1  single-cycle pulse from a one-shot. Starts recording when idle; stops recording when active.
- Keys  input  3  debounced keys: [0]=C, [1]=D, [2]=E.
- ReadOrWrite  output  1  to MusicScore. 1=read (default), 0=write strobe.
- Address  output  AddressBits  RAM address.
- KeyData  output  DataLength  key code being written.
- TimeData  output  DataLength  duration in units being written.
- Recording  output  1  high while in any state other than IDLE.
- Full  output  1  set when the score filled the RAM. Cleared on the next Record start.

Behaviour:
- Reset (async, RESET=0):
  - State=IDLE, ReadOrWrite=1, Address=StartAddress, KeyData=0, TimeData=0, Recording=0, Full=0.
  - Unit and tick counters are cleared.
  - Reset mid-write aborts the write; no partial strobe is emitted.
- Key encoding:
  - No key = 0 (rest); C=1, D=2, E=3.
  - When several keys are down, the lowest index wins.
  - Codes 4..15 are never written.
- Keys are registered once. All decisions use the registered code (one-cycle input latency).
- States:
  - IDLE: Record pulse -> WAIT_KEY. Address=StartAddress, Full=0.
  - WAIT_KEY: leading silence is skipped.
    - First nonzero code -> MEASURE; that code is latched as CurKey; counters are cleared.
    - Record pulse -> END.
  - MEASURE: the tick counter counts 0..TickCycles-1. At wrap, Units increments and saturates at 15.
    - Code != CurKey -> WRITE, then MEASURE with the new code latched; counters restart.
    - Units reaches 15 at a tick wrap with the code unchanged -> WRITE {CurKey,15}, then continue MEASURE with the same CurKey and counters cleared.
    - Record pulse -> WRITE (flush), then END.
  - WRITE: exactly one cycle.
    - ReadOrWrite=0, Address, KeyData=CurKey and TimeData=Units are held stable for the whole cycle.
    - Address increments on the following edge.
    - If Units=0 (segment shorter than one unit), the strobe is suppressed and Address does not advance.
  - END: one cycle writing the marker {Key=0, Time=0} at the current Address, then -> IDLE.
- Capacity:
  - The last address (2^AddressBits-1) is reserved for the marker.
  - If Address reaches 2^AddressBits-1 after a WRITE, go directly to END and set Full=1.
  - No wrap-around ever occurs.
- Simultaneous events:
  - Key change and saturation in the same cycle -> a single write. The new key is latched.
  - Record and key change in the same cycle -> stop wins. The old segment is flushed and the new key is ignored.
  - Record pulse during WRITE or END is ignored.
- Latency: a code change presented on Keys before edge k produces the write strobe during cycle k+2 to k+3.
- Durations are truncated to whole units.

Test Plan:
- Setup for all scenarios: TickCycles=4.
- Basic recording:
  - Stimulus: Record; hold C for 12 cycles; D for 8 cycles; Record.
  - Required: writes addr0={1,3}, addr1={2,2}, addr2={0,0}; Recording falls afterwards; Full=0.
- Saturation:
  - Stimulus: hold E for 70 cycles, then stop.
  - Required: writes {3,15} at addr0; then a remainder entry {3,2} (truncated); then the marker.
- Glitch and leading silence:
  - Stimulus: 20 idle cycles after Record; then D for 2 cycles; then C for 8 cycles; then stop.
  - Required: no write for the silence. No write for the 2-cycle D (Units=0). addr0={1,2}, then the marker at addr1.
- Full:
  - Stimulus: alternate C/D every 4 cycles for 40 entries.
  - Required: addresses 0..30 hold notes; addr31={0,0}; Full=1; IDLE; no write to address 0 again.
- Reset mid-recording:
  - Stimulus: drop RESET during MEASURE and during a WRITE cycle.
  - Required: all outputs return to reset values immediately; no strobe is emitted; a subsequent Record restarts at StartAddress.
- Collision:
  - Stimulus: Record pulse in the same cycle the code changes C->E.
  - Required: C segment written, then marker; no E entry.
